ysyx_24110006_lsu: RTL and testbench
====================================

Name: ysyx_24110006_lsu

Overview:
Load/store stage directly downstream of the execute stage. It consumes the registered execute outputs (memory enables, byte mask, load type, effective address, ALU result) and performs at most one AXI4-Lite-style data access per instruction. For each instruction it delivers one write-back word to the WBU with a single-cycle valid pulse. Non-memory instructions pass through with the ALU result.

Parameters:
ADDR_W, 32, width of the bus address; the low 2 bits select the byte lane.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  one-cycle pulse from the execute stage; its inputs are valid only in that cycle
i_mem_ren  in  1  instruction is a load
i_mem_wen  in  1  instruction is a store
i_mem_wmask  in  4  store size mask, unshifted: 0001, 0011 or 1111
i_mem_read_t  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
i_mem_addr  in  ADDR_W  effective address
i_wdata  in  32  store data (rs2), unshifted
i_result  in  32  ALU result used for non-load write-back
o_valid  out  1  one-cycle pulse: write-back data is valid
o_wb_data  out  32  load data (extended) or pass-through result
o_fault  out  1  qualified by o_valid: bus error (or misalignment, see below)
o_araddr  out  ADDR_W  read address
o_arvalid  out  1  read address valid
i_arready  in  1  read address ready
i_rdata  in  32  read data
i_rresp  in  2  read response
i_rvalid  in  1  read data valid
o_rready  out  1  read data ready
o_awaddr  out  ADDR_W  write address
o_awvalid  out  1  write address valid
i_awready  in  1  write address ready
o_wdata  out  32  write data
o_wstrb  out  4  write byte strobes
o_wvalid  out  1  write data valid
i_wready  in  1  write data ready
i_bresp  in  2  write response
i_bvalid  in  1  write response valid
o_bready  out  1  write response ready

Behaviour:
- Reset: state IDLE. o_valid, o_fault, o_arvalid, o_awvalid, o_wvalid, o_rready and o_bready are all 0. o_wb_data is 0.
- In IDLE, i_valid latches all inputs. i_valid in any other state is ignored; upstream does not issue while the stage is busy.
- FSM states: IDLE, AR, R, WR, B, DONE.
- IDLE to AR when ren=1. IDLE to WR when wen=1. IDLE to DONE when neither is set; ren and wen both set is treated as a load.
- AR: o_arvalid=1 with o_araddr = latched address. On the arvalid&arready handshake, go to R.
- R: o_rready=1. On the rvalid&rready handshake, capture data, set fault = (rresp != 0), go to DONE.
- WR: o_awvalid and o_wvalid both assert on entry. Each deasserts independently after its own handshake, including a same-cycle handshake. Go to B once both handshakes have completed.
- B: o_bready=1. On the bvalid handshake, set fault = (bresp != 0), go to DONE.
- DONE: o_valid=1 for exactly one cycle, then IDLE.
- Latency: a pass-through instruction gives o_valid 2 cycles after i_valid. A load with arready=1 and rvalid one cycle later gives o_valid 4 cycles after i_valid.
- Bus hold rule: valids hold stable until accepted. Addresses and data do not change while their valid is high.
- Store lanes: o_wstrb = wmask << addr[1:0]. o_wdata = wdata << (8*addr[1:0]).
- Load extraction: the byte or half is selected by addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
- Write-back value: o_wb_data = extracted load data for loads, else the latched i_result. For stores o_wb_data = i_result; it is unused downstream.
- On a fault, o_wb_data carries the raw extraction and o_fault=1. The stage does not retry.
- Reset mid-transaction: returns to IDLE next cycle with all valids low. The abandoned transaction is dropped, and the bus slave shares this reset.
- o_valid and bus handshakes never occur in the same cycle.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: a misaligned access is a half access with addr[0]=1, or a word access with addr[1:0]!=0. It skips the bus entirely, goes IDLE to DONE, and returns o_fault=1 with o_wb_data=0.
- Undefined: no check is made. The access is issued with the shifted strobe/data as computed, and upper lanes are truncated.

Decomposition:
- Shared package holds the FSM state encoding, the load-type constants (LB/LH/LW/LBU/LHU), and the AXI response constant OKAY=2'b00.
- One natural sub-module, ysyx_24110006_lsu_align, is purely combinational. It does store lane shifting/strobe generation and load extraction/extension.

Test Plan:
- Pass-through: i_valid, ren=wen=0, i_result=0x1234_5678 -> o_valid exactly 2 cycles later, o_wb_data=0x1234_5678, no bus valids ever high.
- lb at addr 0x8000_0003, rdata=0x80FF_FFFF, arready=1, rvalid 1 cycle after AR -> o_wb_data=0xFFFF_FF80; o_valid 4 cycles after i_valid; o_araddr=0x8000_0003.
- lhu at addr 0x...2, rdata=0xBEEF_0000 -> o_wb_data=0x0000_BEEF. lh on the same data -> 0xFFFF_BEEF.
- sb at addr 0x...1, wdata=0xAB, wmask=0001; awready delayed 3 cycles, wready immediate -> wstrb=0010, wdata=0x0000_AB00; wvalid drops after 1 cycle, awvalid holds until accepted; B then o_valid.
- Error path: load with rresp=2'b10 -> o_valid with o_fault=1. Store with bresp=2'b11 -> o_fault=1. The next op has o_fault=0.
- Reset asserted while in R with rvalid low -> next cycle all outputs at reset values; a following pass-through works normally. With LSU_MISALIGN_CHECK_EN, lw at 0x...2 -> no arvalid, o_fault=1, o_wb_data=0.

Source files
------------

// File: rtl/ysyx_24110006_lsu_pkg.sv
// Shared definitions for the ysyx_24110006 load/store unit.
//   lsu_state_e  : FSM states (IDLE, AR, R, WR, B, DONE)
//   LB..LHU      : load funct3 encodings
//   OKAY         : AXI response code for a successful transfer
package ysyx_24110006_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_WR,
    S_B,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24110006_lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   addr_lo_i  : low two address bits (byte lane)
//   wmask_i    : unshifted store mask (0001/0011/1111)
//   wdata_i    : unshifted store data
//   read_t_i   : load funct3
//   rdata_i    : raw bus read word
//   wstrb_o    : store strobes shifted to the addressed lane (upper lanes truncated)
//   wdata_o    : store data shifted to the addressed lane
//   ld_data_o  : extracted and sign/zero-extended load value
module ysyx_24110006_lsu_align
  import ysyx_24110006_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [3:0]  wmask_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  read_t_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] rshift;

  assign wstrb_o = wmask_i << addr_lo_i;
  assign wdata_o = wdata_i << {addr_lo_i, 3'b000};
  assign rshift  = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    ld_data_o = rdata_i;
    case (read_t_i)
      LB:      ld_data_o = {{24{rshift[7]}}, rshift[7:0]};
      LH:      ld_data_o = {{16{rshift[15]}}, rshift[15:0]};
      LW:      ld_data_o = rdata_i;
      LBU:     ld_data_o = {24'h0, rshift[7:0]};
      LHU:     ld_data_o = {16'h0, rshift[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_lsu.sv
// Load/store stage: one AXI4-Lite-style access per instruction, one
// write-back pulse per instruction to the WBU.
//   i_clock/i_reset         : clock, synchronous active-high reset
//   i_valid + i_mem_*/...   : execute-stage outputs, sampled only in IDLE
//   o_valid/o_wb_data/o_fault : write-back pulse, data and bus/misalign fault
//   o_ar*/i_r* o_aw*/o_w*/i_b* : AXI4-Lite read and write channels
// Optional: define LSU_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses without touching the bus (o_wb_data = 0, o_fault = 1).
module ysyx_24110006_lsu
  import ysyx_24110006_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [3:0]        i_mem_wmask,
  input  logic [2:0]        i_mem_read_t,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_wdata,
  input  logic [31:0]       i_result,
  output logic              o_valid,
  output logic [31:0]       o_wb_data,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [31:0]       i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic              o_awvalid,
  input  logic              i_awready,
  output logic [31:0]       o_wdata,
  output logic [3:0]        o_wstrb,
  output logic              o_wvalid,
  input  logic              i_wready,
  input  logic [1:0]        i_bresp,
  input  logic              i_bvalid,
  output logic              o_bready
);

  lsu_state_e state_q, state_d;

  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic              fault_q, fault_d;
  logic              latch_in;
  logic              capture_r;
  logic              misalign;

  logic              ren_q;
  logic              mis_q;
  logic [3:0]        wmask_q;
  logic [2:0]        read_t_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       result_q;
  logic [31:0]       rdata_q;

  logic              valid_q;
  logic              wb_fault_q;
  logic [31:0]       wb_data_q;
  logic [31:0]       ld_data;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (i_mem_ren) begin
      case (i_mem_read_t)
        LH, LHU: misalign = i_mem_addr[0];
        LW:      misalign = |i_mem_addr[1:0];
        default: misalign = 1'b0;
      endcase
    end else if (i_mem_wen) begin
      case (i_mem_wmask)
        4'b0011: misalign = i_mem_addr[0];
        4'b1111: misalign = |i_mem_addr[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  ysyx_24110006_lsu_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .wmask_i   (wmask_q),
    .wdata_i   (wdata_q),
    .read_t_i  (read_t_q),
    .rdata_i   (rdata_q),
    .wstrb_o   (o_wstrb),
    .wdata_o   (o_wdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    fault_d   = fault_q;
    latch_in  = 1'b0;
    capture_r = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          latch_in = 1'b1;
          fault_d  = 1'b0;
          if (misalign) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else if (i_mem_ren) begin
            state_d = S_AR;
          end else if (i_mem_wen) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_d = S_R;
      end
      S_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          capture_r = 1'b1;
          fault_d   = (i_rresp != OKAY);
          state_d   = S_DONE;
        end
      end
      S_WR: begin
        // AW and W retire independently; move on once neither is pending.
        o_awvalid = aw_pend_q;
        o_wvalid  = w_pend_q;
        if (aw_pend_q && i_awready) aw_pend_d = 1'b0;
        if (w_pend_q && i_wready)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_B;
      end
      S_B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          fault_d = (i_bresp != OKAY);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      fault_q    <= 1'b0;
      ren_q      <= 1'b0;
      mis_q      <= 1'b0;
      wmask_q    <= '0;
      read_t_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      wb_fault_q <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      fault_q   <= fault_d;
      if (latch_in) begin
        ren_q    <= i_mem_ren;
        mis_q    <= misalign;
        wmask_q  <= i_mem_wmask;
        read_t_q <= i_mem_read_t;
        addr_q   <= i_mem_addr;
        wdata_q  <= i_wdata;
        result_q <= i_result;
      end
      if (capture_r) rdata_q <= i_rdata;
      // Write-back is registered out of DONE, so the pulse lands the cycle
      // after DONE and never coincides with a bus handshake.
      valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        wb_fault_q <= fault_q;
        wb_data_q  <= mis_q ? '0 : (ren_q ? ld_data : result_q);
      end
    end
  end

  assign o_valid   = valid_q;
  assign o_fault   = wb_fault_q;
  assign o_wb_data = wb_data_q;
  assign o_araddr  = addr_q;
  assign o_awaddr  = addr_q;

endmodule

// File: tb/tb_ysyx_24110006_lsu.sv
// Directed self-checking bench for ysyx_24110006_lsu. The misaligned-word
// step follows LSU_MISALIGN_CHECK_EN when that macro is defined.
module tb_ysyx_24110006_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_mem_ren, i_mem_wen;
  logic [3:0]  i_mem_wmask;
  logic [2:0]  i_mem_read_t;
  logic [31:0] i_mem_addr, i_wdata, i_result;
  logic        o_valid, o_fault;
  logic [31:0] o_wb_data;
  logic [31:0] o_araddr, o_awaddr, o_wdata;
  logic        o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
  logic [3:0]  o_wstrb;
  logic        i_arready, i_rvalid, i_awready, i_wready, i_bvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp, i_bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24110006_lsu #(.ADDR_W(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid),
    .i_mem_ren(i_mem_ren), .i_mem_wen(i_mem_wen), .i_mem_wmask(i_mem_wmask),
    .i_mem_read_t(i_mem_read_t), .i_mem_addr(i_mem_addr), .i_wdata(i_wdata),
    .i_result(i_result), .o_valid(o_valid), .o_wb_data(o_wb_data),
    .o_fault(o_fault), .o_araddr(o_araddr), .o_arvalid(o_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .o_awaddr(o_awaddr),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_wdata(o_wdata),
    .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [3:0] mask,
                       input logic [2:0] rt, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] res);
    i_valid = 1'b1; i_mem_ren = ren; i_mem_wen = wen; i_mem_wmask = mask;
    i_mem_read_t = rt; i_mem_addr = addr; i_wdata = wd; i_result = res;
    tick();
    i_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0;
    i_mem_addr = 32'hFFFF_FFFF; i_wdata = 32'hFFFF_FFFF; i_result = 32'hFFFF_FFFF;
  endtask

  task automatic check_bus_idle(input string tag);
    chk({tag, "_bus"}, {27'h0, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 32'h0);
  endtask

  task automatic pass_through(input string tag, input logic [31:0] res);
    issue(1'b0, 1'b0, 4'b0000, 3'b000, 32'h0, 32'h0, res);
    chk({tag, "_v1"}, {31'h0, o_valid}, 32'h0);
    check_bus_idle({tag, "_c1"});
    tick();
    chk({tag, "_v2"}, {31'h0, o_valid}, 32'h1);
    chk({tag, "_wb"}, o_wb_data, res);
    chk({tag, "_fault"}, {31'h0, o_fault}, 32'h0);
    check_bus_idle({tag, "_c2"});
    tick();
    chk({tag, "_v3"}, {31'h0, o_valid}, 32'h0);
  endtask

  // arready high throughout, rvalid raised one cycle after the AR handshake.
  task automatic do_load(input string tag, input logic [2:0] rt, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [31:0] exp_wb, input logic exp_fault);
    i_arready = 1'b1;
    issue(1'b1, 1'b0, 4'b0000, rt, addr, 32'h0, 32'h0BAD_0BAD);
    chk({tag, "_arvalid"}, {31'h0, o_arvalid}, 32'h1);
    chk({tag, "_araddr"}, o_araddr, addr);
    tick();
    i_arready = 1'b0;
    chk({tag, "_rready"}, {31'h0, o_rready}, 32'h1);
    chk({tag, "_ar_drop"}, {31'h0, o_arvalid}, 32'h0);
    i_rvalid = 1'b1; i_rdata = rdata; i_rresp = rresp;
    tick();
    i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
    chk({tag, "_v3"}, {31'h0, o_valid}, 32'h0);
    check_bus_idle({tag, "_done"});
    tick();
    chk({tag, "_v4"}, {31'h0, o_valid}, 32'h1);
    chk({tag, "_wb"}, o_wb_data, exp_wb);
    chk({tag, "_fault"}, {31'h0, o_fault}, {31'h0, exp_fault});
    tick();
    chk({tag, "_v5"}, {31'h0, o_valid}, 32'h0);
  endtask

  // wready immediate; awready withheld for aw_hold extra cycles.
  task automatic do_store(input string tag, input logic [3:0] mask, input logic [31:0] addr,
                          input logic [31:0] wd, input int unsigned aw_hold,
                          input logic [1:0] bresp, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input logic exp_fault);
    i_awready = 1'b0; i_wready = 1'b1;
    issue(1'b0, 1'b1, mask, 3'b000, addr, wd, 32'h0000_5A5A);
    chk({tag, "_awvalid"}, {31'h0, o_awvalid}, 32'h1);
    chk({tag, "_wvalid"}, {31'h0, o_wvalid}, 32'h1);
    chk({tag, "_awaddr"}, o_awaddr, addr);
    chk({tag, "_wstrb"}, {28'h0, o_wstrb}, {28'h0, exp_strb});
    chk({tag, "_wdata"}, o_wdata, exp_wdata);
    for (int unsigned i = 0; i < aw_hold; i++) begin
      tick();
      chk({tag, "_w_drop"}, {31'h0, o_wvalid}, 32'h0);
      chk({tag, "_aw_hold"}, {31'h0, o_awvalid}, 32'h1);
      chk({tag, "_awaddr_hold"}, o_awaddr, addr);
    end
    i_awready = 1'b1;
    tick();
    i_awready = 1'b0; i_wready = 1'b0;
    chk({tag, "_b_chan"}, {29'h0, o_awvalid, o_wvalid, o_bready}, 32'h1);
    i_bvalid = 1'b1; i_bresp = bresp;
    tick();
    i_bvalid = 1'b0; i_bresp = 2'b00;
    chk({tag, "_v_done"}, {31'h0, o_valid}, 32'h0);
    check_bus_idle({tag, "_done"});
    tick();
    chk({tag, "_valid"}, {31'h0, o_valid}, 32'h1);
    chk({tag, "_fault"}, {31'h0, o_fault}, {31'h0, exp_fault});
    chk({tag, "_wb"}, o_wb_data, 32'h0000_5A5A);
    tick();
    chk({tag, "_v_end"}, {31'h0, o_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 1'b0; i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_mem_wmask = 4'h0;
    i_mem_read_t = 3'h0; i_mem_addr = 32'h0; i_wdata = 32'h0; i_result = 32'h0;
    i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_fault", {31'h0, o_fault}, 32'h0);
    chk("rst_wb", o_wb_data, 32'h0);
    check_bus_idle("rst");

    pass_through("pt", 32'h1234_5678);

    do_load("lb",  3'b000, 32'h8000_0003, 32'h80FF_FFFF, 2'b00, 32'hFFFF_FF80, 1'b0);
    do_load("lhu", 3'b101, 32'h8000_0002, 32'hBEEF_0000, 2'b00, 32'h0000_BEEF, 1'b0);
    do_load("lh",  3'b001, 32'h8000_0002, 32'hBEEF_0000, 2'b00, 32'hFFFF_BEEF, 1'b0);
    do_load("lbu", 3'b100, 32'h8000_0001, 32'h1234_8056, 2'b00, 32'h0000_0080, 1'b0);
    do_load("lw",  3'b010, 32'h8000_0000, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);

    do_store("sb", 4'b0001, 32'h8000_0001, 32'h0000_00AB, 2, 2'b00,
             4'b0010, 32'h0000_AB00, 1'b0);
    do_store("sh", 4'b0011, 32'h8000_0002, 32'h0000_1234, 0, 2'b00,
             4'b1100, 32'h1234_0000, 1'b0);

    do_load("ld_err", 3'b010, 32'h8000_0008, 32'h1122_3344, 2'b10, 32'h1122_3344, 1'b1);
    do_store("st_err", 4'b1111, 32'h8000_0004, 32'hCAFE_F00D, 1, 2'b11,
             4'b1111, 32'hCAFE_F00D, 1'b1);
    pass_through("pt_after_err", 32'h0000_00A5);

    // Reset while waiting in R with rvalid low.
    i_arready = 1'b1;
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h8000_0010, 32'h0, 32'h0);
    tick();
    i_arready = 1'b0;
    chk("mid_in_r", {31'h0, o_rready}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bus_idle("mid_rst");
    chk("mid_rst_valid", {31'h0, o_valid}, 32'h0);
    chk("mid_rst_wb", o_wb_data, 32'h0);
    tick();
    check_bus_idle("mid_rst_hold");
    pass_through("pt_after_rst", 32'h0F0F_1234);

`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, 4'b0000, 3'b010, 32'h8000_0002, 32'h0, 32'h0);
    chk("mis_arvalid", {31'h0, o_arvalid}, 32'h0);
    tick();
    chk("mis_valid", {31'h0, o_valid}, 32'h1);
    chk("mis_fault", {31'h0, o_fault}, 32'h1);
    chk("mis_wb", o_wb_data, 32'h0);
    check_bus_idle("mis");
    tick();
`else
    do_load("lw_mis", 3'b010, 32'h8000_0002, 32'hAABB_CCDD, 2'b00, 32'hAABB_CCDD, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
